vec_config_unit: RTL and testbench

//  Sequential vsetvli/vsetivli/vsetvl execution unit. Sits between the scalar-core issue interface and the vector CSR file.

---
 rtl/vec_config_unit.sv | 209 ++++++++++++++++++++
 tb/tb_vec_config_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_config_unit.sv
// Sequential vsetvli/vsetivli/vsetvl unit that owns vl/vtype and returns the new vl to rd.
// Optional feature macro: VEC_CFG_FRAC_LMUL_EN enables the fractional LMUL (mf8/mf4/mf2) settings.
module vec_config_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned VLEN = 512,
    parameter int unsigned ELEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [XLEN-1:0] vec_inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      rd_addr,
    output logic            rd_wr_en,
    output logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] csr_vl,
    output logic [XLEN-1:0] csr_vtype
);

    localparam int unsigned HI_W   = 17;
    localparam logic [6:0]  OPC_V  = 7'b1010111;
    localparam logic [2:0]  F3_CFG = 3'b111;
    localparam logic [XLEN-1:0] VTYPE_ILL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   calc_phase, calc_phase_nxt;
    logic   accept_c, eval_c, commit_c, done_c;
    logic   is_cfg_c;

    // Latched instruction: only bits [31:15] and rd carry information for the datapath.
    logic [HI_W-1:0] inst_hi_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rs1_q, rs2_q;

    logic [XLEN-1:0] vlmax_q, avl_q, vtype_q, vlmax_cur;
    logic            ill_q;

    logic            is_vli_c, is_ivli_c, keep_c, ill_c;
    logic [4:0]      rs1_f_c, uimm_c;
    logic [XLEN-1:0] vtype_c, sew_c, base_c, vlmax_c, avl_c, vl_c;
    logic [2:0]      vsew_c, vlmul_c;

    assign is_cfg_c = (vec_inst[6:0] == OPC_V) && (vec_inst[14:12] == F3_CFG);

    // State register; CALC spends two cycles (evaluate, then commit).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            calc_phase <= 1'b0;
        end else begin
            state      <= state_nxt;
            calc_phase <= calc_phase_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        calc_phase_nxt = 1'b0;
        accept_c       = 1'b0;
        eval_c         = 1'b0;
        commit_c       = 1'b0;
        done_c         = 1'b0;
        case (state)
            S_IDLE: begin
                if (inst_valid && is_cfg_c) begin
                    accept_c  = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (!calc_phase) begin
                    eval_c         = 1'b1;
                    calc_phase_nxt = 1'b1;
                end else begin
                    commit_c  = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    done_c    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign is_vli_c  = !inst_hi_q[16];
    assign is_ivli_c = inst_hi_q[16] && inst_hi_q[15];
    assign rs1_f_c   = inst_hi_q[4:0];
    assign uimm_c    = inst_hi_q[4:0];
    assign keep_c    = !is_ivli_c && (rs1_f_c == 5'd0) && (rd_q == 5'd0);

    always_comb begin
        vtype_c = rs2_q;
        if (is_vli_c) begin
            vtype_c = XLEN'(inst_hi_q[15:5]);
        end else if (is_ivli_c) begin
            vtype_c = XLEN'(inst_hi_q[14:5]);
        end
    end

    assign vsew_c  = vtype_c[5:3];
    assign vlmul_c = vtype_c[2:0];
    assign sew_c   = XLEN'(8) << vsew_c;
    assign base_c  = XLEN'(VLEN) >> (4'(vsew_c) + 4'd3);

    // VLMAX and legality of the requested vtype, including the keep-vl rule.
    always_comb begin
        vlmax_c = '0;
        ill_c   = (|vtype_c[XLEN-1:8]) || vsew_c[2] || (sew_c > XLEN'(ELEN)) || (vlmul_c == 3'd4);
        if (!vlmul_c[2]) begin
            vlmax_c = base_c << vlmul_c[1:0];
        end else if (vlmul_c != 3'd4) begin
`ifdef VEC_CFG_FRAC_LMUL_EN
            vlmax_c = base_c >> (4'd8 - 4'(vlmul_c));
            if ((sew_c > (XLEN'(ELEN) >> (4'd8 - 4'(vlmul_c)))) || (vlmax_c == '0)) begin
                ill_c = 1'b1;
            end
`else
            ill_c = 1'b1;
`endif
        end
        if (keep_c && (vlmax_c != vlmax_cur)) begin
            ill_c = 1'b1;
        end
    end

    always_comb begin
        avl_c = '1;
        if (is_ivli_c) begin
            avl_c = XLEN'(uimm_c);
        end else if (rs1_f_c != 5'd0) begin
            avl_c = rs1_q;
        end else if (rd_q == 5'd0) begin
            avl_c = csr_vl;
        end
    end

    assign vl_c = (avl_q < vlmax_q) ? avl_q : vlmax_q;

    // Operand capture, evaluation stage, CSR commit and response channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_ready <= 1'b1;
            inst_hi_q  <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            vlmax_q    <= '0;
            avl_q      <= '0;
            vtype_q    <= '0;
            ill_q      <= 1'b0;
            vlmax_cur  <= '0;
            resp_valid <= 1'b0;
            rd_addr    <= '0;
            rd_wr_en   <= 1'b0;
            rd_data    <= '0;
            csr_vl     <= '0;
            csr_vtype  <= VTYPE_ILL;
        end else begin
            inst_ready <= (state_nxt == S_IDLE);
            if (accept_c) begin
                inst_hi_q <= vec_inst[31:15];
                rd_q      <= vec_inst[11:7];
                rs1_q     <= rs1_data;
                rs2_q     <= rs2_data;
            end
            if (eval_c) begin
                vlmax_q <= vlmax_c;
                avl_q   <= avl_c;
                vtype_q <= vtype_c;
                ill_q   <= ill_c;
            end
            if (commit_c) begin
                resp_valid <= 1'b1;
                rd_addr    <= rd_q;
                rd_wr_en   <= (rd_q != 5'd0);
                if (ill_q) begin
                    csr_vl    <= '0;
                    csr_vtype <= VTYPE_ILL;
                    rd_data   <= '0;
                    vlmax_cur <= '0;
                end else begin
                    csr_vl    <= vl_c;
                    csr_vtype <= vtype_q;
                    rd_data   <= vl_c;
                    vlmax_cur <= vlmax_q;
                end
            end
            if (done_c) begin
                resp_valid <= 1'b0;
                rd_wr_en   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vec_config_unit.sv
// Self-checking bench for vec_config_unit: directed cases plus randomized config traffic vs a reference model.
module tb_vec_config_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned VLEN = 512;
    localparam int unsigned ELEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] vec_inst, rs1_data, rs2_data;
    logic        resp_valid, resp_ready;
    logic [4:0]  rd_addr;
    logic        rd_wr_en;
    logic [31:0] rd_data, csr_vl, csr_vtype;

    int cmp = 0;
    int mis = 0;

    logic [31:0] m_vl, m_vtype;
    logic [31:0] exp_rd_data;
    logic [4:0]  exp_rd;

    vec_config_unit #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .vec_inst(vec_inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .rd_addr(rd_addr),
        .rd_wr_en(rd_wr_en), .rd_data(rd_data), .csr_vl(csr_vl), .csr_vtype(csr_vtype)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: VLMAX = VLEN * LMUL / SEW with LMUL as a fraction num/den.
    function automatic void ref_vlmax(input logic [31:0] vt, output bit ill, output longint vlmax);
        int     vsew  = int'(vt[5:3]);
        int     vlmul = int'(vt[2:0]);
        longint sew, num, den;
        num = 1;
        den = 1;
        ill = (vt[31:8] != 0) || (vsew > 3) || (vlmul == 4);
        sew = longint'(8) << vsew;
        if (sew > ELEN) ill = 1;
        if (vlmul < 4) num = longint'(1) << vlmul;
        else if (vlmul > 4) begin
            den = longint'(1) << (8 - vlmul);
`ifdef VEC_CFG_FRAC_LMUL_EN
            if (sew * den > ELEN) ill = 1;
`else
            ill = 1;
`endif
        end
        vlmax = (longint'(VLEN) * num) / (sew * den);
        if (vlmax == 0) ill = 1;
        if (ill) vlmax = 0;
    endfunction

    task automatic model_cfg(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
        logic [31:0] vt;
        longint      avl, vlmax, old_vlmax, vl;
        bit          ill, old_ill;
        logic [4:0]  rd = inst[11:7];
        logic [4:0]  rs1f = inst[19:15];
        if (!inst[31])      vt = {21'd0, inst[30:20]};
        else if (inst[30])  vt = {22'd0, inst[29:20]};
        else                vt = r2;
        ref_vlmax(vt, ill, vlmax);
        if (inst[31:30] == 2'b11)  avl = longint'(rs1f);
        else if (rs1f != 0)        avl = longint'(r1);
        else if (rd != 0)          avl = longint'(32'hFFFF_FFFF);
        else begin
            ref_vlmax(m_vtype, old_ill, old_vlmax);
            if (old_ill || old_vlmax != vlmax) ill = 1;
            avl = longint'(m_vl);
        end
        vl = (avl < vlmax) ? avl : vlmax;
        if (ill) begin
            m_vl    = 32'd0;
            m_vtype = 32'h8000_0000;
        end else begin
            m_vl    = 32'(vl);
            m_vtype = vt;
        end
        exp_rd_data = m_vl;
        exp_rd      = rd;
    endtask

    // Issue one config instruction and check latency, response, CSRs and backpressure.
    task automatic do_cfg(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2, input int hold);
        logic [31:0] held;
        @(negedge clk);
        chk("idle_ready", 32'(inst_ready), 32'd1);
        inst_valid = 1'b1;
        vec_inst   = inst;
        rs1_data   = r1;
        rs2_data   = r2;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        rs1_data   = $urandom;
        rs2_data   = $urandom;
        model_cfg(inst, r1, r2);
        chk("calc_busy", 32'(inst_ready), 32'd0);
        @(posedge clk); #1;
        chk("no_early_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_data", rd_data, exp_rd_data);
        chk("rd_addr", 32'(rd_addr), 32'(exp_rd));
        chk("rd_wr_en", 32'(rd_wr_en), 32'(exp_rd != 5'd0));
        chk("csr_vl", csr_vl, m_vl);
        chk("csr_vtype", csr_vtype, m_vtype);
        held = rd_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            inst_valid = 1'b1;
            vec_inst   = 32'h0000_7057 | (32'($urandom_range(1, 31)) << 15);
            rs1_data   = 32'd7;
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", rd_data, held);
            chk("hold_ready", 32'(inst_ready), 32'd0);
            chk("hold_vl", csr_vl, m_vl);
        end
        @(negedge clk);
        inst_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("ready_again", 32'(inst_ready), 32'd1);
    endtask

    task automatic do_other(input logic [31:0] inst);
        @(negedge clk);
        inst_valid = 1'b1;
        vec_inst   = inst;
        rs1_data   = $urandom;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        chk("other_ready", 32'(inst_ready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("other_noresp", 32'(resp_valid), 32'd0);
        chk("other_vl", csr_vl, m_vl);
        chk("other_vtype", csr_vtype, m_vtype);
    endtask

    function automatic logic [31:0] mk_vli(input logic [10:0] zimm, input logic [4:0] rs1, input logic [4:0] rd);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] mk_ivli(input logic [9:0] zimm, input logic [4:0] uimm, input logic [4:0] rd);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] mk_vl(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] rnd_vtype();
        logic [31:0] vt;
        vt = {24'd0, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 7))};
        if ($urandom_range(0, 9) == 0) vt[8 + $urandom_range(0, 2)] = 1'b1;
        return vt;
    endfunction

    initial begin
        logic [31:0] vt, r1;
        int          kind;
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        resp_ready = 1'b0;
        vec_inst   = '0;
        rs1_data   = '0;
        rs2_data   = '0;
        m_vl       = 32'd0;
        m_vtype    = 32'h8000_0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(inst_ready), 32'd1);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_vl", csr_vl, 32'd0);
        chk("rst_vtype", csr_vtype, 32'h8000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // e32,m1 with AVL=100
        do_cfg(mk_vli(11'h010, 5'd6, 5'd5), 32'd100, 32'd0, 0);
        chk("t1_vl16", csr_vl, 32'd16);
        chk("t1_vtype", csr_vtype, 32'h10);
        // keep vl at same VLMAX, rd=x0
        do_cfg(mk_vli(11'h010, 5'd0, 5'd0), 32'd0, 32'd0, 1);
        chk("t4_keep", csr_vl, 32'd16);
        // keep vl with changed VLMAX is illegal
        do_cfg(mk_vli(11'h000, 5'd0, 5'd0), 32'd0, 32'd0, 0);
        chk("t4_vill", csr_vtype, 32'h8000_0000);
        // vsetivli uimm=5 e8,m2 then AVL=all-ones
        do_cfg(mk_ivli(10'h001, 5'd5, 5'd1), 32'd0, 32'd0, 0);
        chk("t2_vl5", csr_vl, 32'd5);
        do_cfg(mk_vli(11'h001, 5'd0, 5'd2), 32'd0, 32'd0, 0);
        chk("t2_vl128", csr_vl, 32'd128);
        // e64 exceeds ELEN
        do_cfg(mk_vl(5'd7, 5'd3, 5'd4), 32'd10, 32'h18, 0);
        chk("t3_vill", csr_vtype, 32'h8000_0000);
        chk("t3_vl0", rd_data, 32'd0);
        // long backpressure with a pending second instruction
        do_cfg(mk_vli(11'h012, 5'd9, 5'd8), 32'd1000, 32'd0, 4);
        chk("t5_vl64", csr_vl, 32'd64);
        // fractional mf2 e8
        do_cfg(mk_vli(11'h007, 5'd6, 5'd3), 32'd1000, 32'd0, 0);
        do_other(32'h0020_8033);

        // reset while in CALC drops the instruction
        @(negedge clk);
        inst_valid = 1'b1;
        vec_inst   = mk_vli(11'h010, 5'd6, 5'd5);
        rs1_data   = 32'd3;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_vl    = 32'd0;
        m_vtype = 32'h8000_0000;
        chk("t6_vl", csr_vl, 32'd0);
        chk("t6_vtype", csr_vtype, 32'h8000_0000);
        chk("t6_ready", 32'(inst_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_noresp", 32'(resp_valid), 32'd0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            vt   = rnd_vtype();
            r1   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case (kind)
                0: do_cfg(mk_vli(vt[10:0], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))), r1, 32'd0,
                          $urandom_range(0, 2));
                1: do_cfg(mk_ivli(vt[9:0], 5'($urandom), 5'($urandom_range(0, 3))), r1, 32'd0,
                          $urandom_range(0, 2));
                2: begin
                    if ($urandom_range(0, 9) == 0) vt[8 + $urandom_range(0, 22)] = 1'b1;
                    do_cfg(mk_vl(5'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))), r1, vt,
                           $urandom_range(0, 2));
                end
                default: do_other({$urandom_range(0, 32'h01FF_FFFF), 7'b0110011});
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
